div_unit: RTL and testbench

- Multi-cycle RV32M divider (DIV, DIVU, REM, REMU) between the register file read ports and the register file write port.
- Takes rs1/rs2 operand values and a destination register index.
- Returns the result with a one-cycle write strobe, stalling the core via busy while it iterates.
- Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/div_unit_if.sv | 18 +
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the core issue stage and the RV32M divider.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       rd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_out;
  logic             reg_write;

  modport master (output start, op, op_a, op_b, rd_in,
                  input  busy, done, result, rd_out, reg_write);
  modport slave  (input  start, op, op_a, op_b, rd_in,
                  output busy, done, result, rd_out, reg_write);
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration (IDLE -> DONE).
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, busy=1, WIDTH cycles
// DONE  | done=1 for one cycle with result/rd_out
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  div_unit_if.slave bus
);

`ifdef DIV_EARLY_OUT_EN
  localparam logic EARLY_OUT = 1'b1;
`else
  localparam logic EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, a_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rem_sel_q, sign_q, sign_r, div0_q, ovf_q;
  logic [4:0]       rd_q, rd_out_q;
  logic             done_q, reg_write_q;

  logic             is_signed_in, div0_in, ovf_in, early_in, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] quo_step, rem_step, fin_q, fin_r, calc_result;

  function automatic logic [WIDTH-1:0] special_val(input logic rem_sel,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic div0);
    if (rem_sel) return div0 ? a : '0;
    else         return div0 ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  assign is_signed_in = ~bus.op[0];
  assign mag_a    = (is_signed_in && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign mag_b    = (is_signed_in && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign div0_in  = (bus.op_b == '0);
  assign ovf_in   = is_signed_in && (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op_b == '1);
  assign early_in = EARLY_OUT && (div0_in || ovf_in);
  assign accept   = bus.start && (state != CALC);

  // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_step = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign fin_q    = sign_q ? -quo_step : quo_step;
  assign fin_r    = sign_r ? -rem_step : rem_step;
  assign calc_result = (div0_q || ovf_q) ? special_val(rem_sel_q, a_q, div0_q)
                                         : (rem_sel_q ? fin_r : fin_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = bus.start ? (early_in ? DONE : CALC) : IDLE;
      CALC:       if (cnt_q == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      a_q         <= '0;
      cnt_q       <= '0;
      rem_sel_q   <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      rd_out_q    <= '0;
      done_q      <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      reg_write_q <= 1'b0;
      if (accept) begin
        quo_q     <= mag_a;
        dvs_q     <= mag_b;
        a_q       <= bus.op_a;
        rem_q     <= '0;
        cnt_q     <= CNT_W'(WIDTH - 1);
        rem_sel_q <= bus.op[1];
        sign_q    <= is_signed_in && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
        sign_r    <= is_signed_in && bus.op_a[WIDTH-1];
        div0_q    <= div0_in;
        ovf_q     <= ovf_in;
        rd_q      <= bus.rd_in;
        if (early_in) begin
          result_q    <= special_val(bus.op[1], bus.op_a, div0_in);
          rd_out_q    <= bus.rd_in;
          done_q      <= 1'b1;
          reg_write_q <= (bus.rd_in != 5'd0);
        end
      end else if (state == CALC) begin
        quo_q <= quo_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          result_q    <= calc_result;
          rd_out_q    <= rd_q;
          done_q      <= 1'b1;
          reg_write_q <= (rd_q != 5'd0);
        end
      end
    end
  end

  assign bus.busy      = (state == CALC);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.rd_out    = rd_out_q;
  assign bus.reg_write = reg_write_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, negedge monitor pops on done.
module tb_div_unit;
  localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint la, lb;
    logic   ovf;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(la / lb));
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(la % lb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string name);
    exp_t e;
    logic special;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.res  = ref_model(op, a, b);
    e.rd   = rd;
    e.rw   = (rd != 0);
    e.cyc  = cyc + ((EARLY && special) ? 1 : 1 + W);
    e.name = name;
    sb.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input string name);
    issue(op, a, b, rd, name);
    wait_done(name);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("regw_without_done", {63'd0, bus.reg_write & ~bus.done}, 64'd0);
        if (bus.done) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: result %0h rd %0d at cycle %0d", bus.result, bus.rd_out, cyc);
          end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, 64'(bus.result), 64'(e.res));
            check({e.name, "_rd"}, 64'(bus.rd_out), 64'(e.rd));
            check({e.name, "_regw"}, 64'(bus.reg_write), 64'(e.rw));
            check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_done", 64'(bus.done), 64'd0);
      check("idle_regw", 64'(bus.reg_write), 64'd0);
      check("idle_result", 64'(bus.result), 64'd0);
    end

    // Consecutive runs start in the DONE cycle, so these also exercise back-to-back.
    run(2'd0, 32'hFFFF_FF9C, 32'd7, 5'd5, "div_neg100_7");
    run(2'd2, 32'hFFFF_FF9C, 32'd7, 5'd5, "rem_neg100_7");
    run(2'd1, 32'hFFFF_FFFF, 32'h10, 5'd3, "divu_max_16");
    run(2'd3, 32'hFFFF_FFFF, 32'h10, 5'd3, "remu_max_16");
    run(2'd0, 32'h1234, 32'd0, 5'd7, "div_by_zero");
    run(2'd2, 32'h1234, 32'd0, 5'd7, "rem_by_zero");
    run(2'd1, 32'h1234, 32'd0, 5'd8, "divu_by_zero");
    run(2'd3, 32'h1234, 32'd0, 5'd8, "remu_by_zero");
    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "div_overflow");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "rem_overflow");
    run(2'd1, 32'd100, 32'd3, 5'd0, "divu_rd0");
    repeat (3) @(negedge clk);

    issue(2'd1, 32'd1000, 32'd7, 5'd11, "divu_ignore_2nd");
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.op_a = 32'd55; bus.op_b = 32'd0; bus.rd_in = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("divu_ignore_2nd");

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run(op, a, b, 5'($urandom), $sformatf("rand%0d_op%0d", i, op));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abort an operation mid-iteration: the pending entry is dropped, nothing may complete.
    repeat (2) @(negedge clk);
    issue(2'd0, 32'hDEAD_BEEF, 32'd13, 5'd4, "aborted");
    repeat (9) @(negedge clk);
    check("busy_before_reset", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("busy_async_reset", 64'(bus.busy), 64'd0);
    check("done_async_reset", 64'(bus.done), 64'd0);
    check("result_async_reset", 64'(bus.result), 64'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(2'd1, 32'd100, 32'd3, 5'd6, "after_reset");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
